// File: rtl/mips_multicycle_control.sv
// ============================================================================
// Module   : mips_multicycle_control
// Function : Control FSM sequencing a multicycle MIPS datapath, with a
//            mem_ready handshake and a timeout that aborts stalled accesses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multicycle_control #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state
);

  localparam int c_CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEM_ADR = 4'd3,
    MEM_RD  = 4'd4,
    MEM_WB  = 4'd5,
    MEM_WR  = 4'd6,
    EXEC    = 4'd7,
    ALU_WB  = 4'd8,
    BRANCH  = 4'd9,
    JUMP    = 4'd10,
    ADDI_EX = 4'd11,
    ADDI_WB = 4'd12
  } stateT;

  // State-only controls, registered from the next state so they are glitch-free.
  typedef struct packed {
    logic       pcWriteU;
    logic       pcWriteCond;
    logic       iOrD;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
  } ctrlT;

  stateT              r_state;
  stateT              w_nextState;
  ctrlT               r_ctrl;
  logic [c_CNT_W-1:0] r_waitCnt;
  logic               r_isLoad;
  logic               w_waiting;
  logic               w_expired;
  logic               w_legal;

  function automatic ctrlT ctrlFor(input stateT s);
    ctrlT c;
    c = '0;
    case (s)
      FETCH:   begin c.memRead = 1'b1; c.aluSrcB = 2'b01; end
      DECODE:  c.aluSrcB = 2'b11;
      MEM_ADR: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
      MEM_RD:  begin c.memRead = 1'b1; c.iOrD = 1'b1; end
      MEM_WB:  begin c.regWrite = 1'b1; c.memToReg = 1'b1; end
      MEM_WR:  begin c.memWrite = 1'b1; c.iOrD = 1'b1; end
      EXEC:    begin c.aluSrcA = 1'b1; c.aluOp = 2'b10; end
      ALU_WB:  begin c.regWrite = 1'b1; c.regDst = 1'b1; end
      BRANCH:  begin
        c.aluSrcA     = 1'b1;
        c.aluOp       = 2'b01;
        c.pcWriteCond = 1'b1;
        c.pcSource    = 2'b01;
      end
      JUMP:    begin c.pcWriteU = 1'b1; c.pcSource = 2'b10; end
      ADDI_EX: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
      ADDI_WB: c.regWrite = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    w_waiting = (r_state == FETCH) || (r_state == MEM_RD) || (r_state == MEM_WR);
    w_expired = w_waiting && !mem_ready && (r_waitCnt == c_CNT_LAST);
    w_legal   = (opcode == c_OP_RTYPE) || (opcode == c_OP_LW) || (opcode == c_OP_SW) ||
                (opcode == c_OP_BEQ) || (opcode == c_OP_J) || (opcode == c_OP_ADDI);

    w_nextState = IDLE;
    case (r_state)
      IDLE:    w_nextState = FETCH;
      FETCH:   w_nextState = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          c_OP_RTYPE:      w_nextState = EXEC;
          c_OP_LW, c_OP_SW: w_nextState = MEM_ADR;
          c_OP_BEQ:        w_nextState = BRANCH;
          c_OP_J:          w_nextState = JUMP;
          c_OP_ADDI:       w_nextState = ADDI_EX;
          default:         w_nextState = FETCH;
        endcase
      end
      MEM_ADR: w_nextState = r_isLoad ? MEM_RD : MEM_WR;
      MEM_RD:  w_nextState = mem_ready ? MEM_WB : (w_expired ? FETCH : MEM_RD);
      MEM_WR:  w_nextState = (mem_ready || w_expired) ? FETCH : MEM_WR;
      EXEC:    w_nextState = ALU_WB;
      ADDI_EX: w_nextState = ADDI_WB;
      MEM_WB, ALU_WB, ADDI_WB, BRANCH, JUMP: w_nextState = FETCH;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ctrl    <= '0;
      r_waitCnt <= '0;
      r_isLoad  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_ctrl  <= ctrlFor(w_nextState);
      if (r_state == DECODE)
        r_isLoad <= (opcode == c_OP_LW);
      // Any state change or a FETCH self-restart begins a fresh wait window.
      if (w_expired || (w_nextState != r_state))
        r_waitCnt <= '0;
      else if (w_waiting)
        r_waitCnt <= r_waitCnt + c_CNT_W'(1);
    end
  end

  assign ir_write      = (r_state == FETCH) && mem_ready;
  assign pc_write      = r_ctrl.pcWriteU || ir_write;
  assign pc_write_cond = r_ctrl.pcWriteCond;
  assign i_or_d        = r_ctrl.iOrD;
  assign mem_read      = r_ctrl.memRead;
  assign mem_write     = r_ctrl.memWrite;
  assign mem_to_reg    = r_ctrl.memToReg;
  assign reg_dst       = r_ctrl.regDst;
  assign reg_write     = r_ctrl.regWrite;
  assign alu_src_a     = r_ctrl.aluSrcA;
  assign alu_src_b     = r_ctrl.aluSrcB;
  assign alu_op        = r_ctrl.aluOp;
  assign pc_source     = r_ctrl.pcSource;
  assign illegal_op    = (r_state == DECODE) && !w_legal;
  assign mem_err       = w_expired;
  assign state         = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
// ============================================================================
// Module   : tb_mips_multicycle_control
// Function : Self-checking bench for mips_multicycle_control against an
//            instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_multicycle_control;

  localparam int T = 16;
  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B,
                         OP_BEQ = 6'h04, OP_J = 6'h02, OP_ADDI = 6'h08, OP_BAD = 6'h3F;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, mem_err;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  mips_multicycle_control #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .mem_err(mem_err), .state(state)
  );

  always #5 clk = ~clk;

  wire [21:0] dutV = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                      pc_source, illegal_op, mem_err, state};

  // Reference model: current step of the instruction and cycles already waited in it.
  int mState = 0;
  int mWaited = 0;
  bit mIsLw = 0;
  int mNext;
  bit mStall, mTimeout;

  function automatic bit isLegal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  endfunction

  // Expected output word from the per-state table; memory waits add the handshake terms.
  function automatic logic [21:0] expOut(input int s, input logic mr, input logic [5:0] op,
                                         input int waited);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, ill, merr;
    logic [1:0] sb, ao, ps;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, ill, merr} = '0;
    sb = 2'd0; ao = 2'd0; ps = 2'd0;
    if (s inside {1, 4, 6}) merr = !mr && (waited == T - 1);
    case (s)
      1:  begin mrd = 1; sb = 2'd1; irw = mr; pcw = mr; end
      2:  begin sb = 2'd3; ill = !isLegal(op); end
      3:  begin sa = 1; sb = 2'd2; end
      4:  begin mrd = 1; iord = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin mwr = 1; iord = 1; end
      7:  begin sa = 1; ao = 2'd2; end
      8:  begin rw = 1; rdst = 1; end
      9:  begin sa = 1; ao = 2'd1; pcwc = 1; ps = 2'd1; end
      10: begin pcw = 1; ps = 2'd2; end
      11: begin sa = 1; sb = 2'd2; end
      12: rw = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, ao, ps, ill, merr, 4'(s)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mState  = 0;
      mWaited = 0;
    end else begin
      mStall   = (mState inside {1, 4, 6}) && !mem_ready;
      mTimeout = mStall && (mWaited == T - 1);
      case (mState)
        0: mNext = 1;
        1: mNext = mem_ready ? 2 : 1;
        2: begin
          mIsLw = (opcode == OP_LW);
          if (opcode == OP_R) mNext = 7;
          else if (opcode == OP_LW || opcode == OP_SW) mNext = 3;
          else if (opcode == OP_BEQ) mNext = 9;
          else if (opcode == OP_J) mNext = 10;
          else if (opcode == OP_ADDI) mNext = 11;
          else mNext = 1;
        end
        3: mNext = mIsLw ? 4 : 6;
        4: mNext = mem_ready ? 5 : (mTimeout ? 1 : 4);
        6: mNext = (mem_ready || mTimeout) ? 1 : 6;
        7: mNext = 8;
        11: mNext = 12;
        5, 8, 9, 10, 12: mNext = 1;
        default: mNext = 0;
      endcase
      mWaited = (mStall && !mTimeout) ? mWaited + 1 : 0;
      mState  = mNext;
    end
  end

  always @(negedge clk) begin
    logic [21:0] e;
    e = expOut(mState, mem_ready, opcode, mWaited);
    checks++;
    if (dutV !== e) begin
      errors++;
      $display("FAIL model_compare t=%0t: dut=%h expected=%h (model state %0d)", $time, dutV, e, mState);
    end
  end

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Apply inputs for the coming cycle, then stop at its sample point.
  task automatic drive(input logic mr, input logic [5:0] op);
    @(posedge clk);
    #1;
    mem_ready = mr;
    opcode    = op;
    @(negedge clk);
  endtask

  logic [5:0] opTab [7];
  int memWriteCycles;

  initial begin
    opTab = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_BAD};
    rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'h00;
    repeat (2) begin
      @(negedge clk);
      expect_eq("reset_outputs_zero", 32'(dutV), 32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b1; opcode = OP_LW;
    @(negedge clk);
    expect_eq("idle_after_reset", 32'(dutV), 32'h0);

    // lw with a one-cycle memory
    drive(1, OP_LW);
    expect_eq("fetch_state", 32'(state), 1);
    expect_eq("fetch_ir_pc_write", {30'd0, ir_write, pc_write}, 32'h3);
    drive(1, OP_LW); expect_eq("lw_decode", 32'(state), 2);
    drive(1, OP_LW); expect_eq("lw_memadr", 32'(state), 3);
    drive(1, OP_LW); expect_eq("lw_memrd", 32'(state), 4);
    expect_eq("lw_memrd_noreg", 32'(reg_write), 0);
    drive(1, OP_LW); expect_eq("lw_memwb", 32'(state), 5);
    expect_eq("lw_wb_strobes", {30'd0, reg_write, mem_to_reg}, 32'h3);
    drive(1, OP_LW); expect_eq("lw_back_fetch", 32'(state), 1);

    // R-type
    drive(1, OP_R); expect_eq("r_decode", 32'(state), 2);
    drive(1, OP_R); expect_eq("r_exec", 32'(state), 7);
    expect_eq("r_exec_aluop", 32'(alu_op), 2);
    drive(1, OP_R); expect_eq("r_aluwb", 32'(state), 8);
    expect_eq("r_wb_strobes", {30'd0, reg_write, reg_dst}, 32'h3);
    drive(1, OP_R); expect_eq("r_back_fetch", 32'(state), 1);

    // sw with three stalled cycles
    drive(1, OP_SW); drive(1, OP_SW);
    expect_eq("sw_memadr", 32'(state), 3);
    memWriteCycles = 0;
    for (int i = 0; i < 4; i++) begin
      drive(i == 3, OP_SW);
      expect_eq("sw_memwr_state", 32'(state), 6);
      expect_eq("sw_no_regwrite", 32'(reg_write), 0);
      if (mem_write) memWriteCycles++;
    end
    expect_eq("sw_memwrite_cycles", 32'(memWriteCycles), 4);
    drive(1, OP_SW); expect_eq("sw_back_fetch", 32'(state), 1);

    // lw with memory stuck in MEM_RD
    drive(1, OP_LW); drive(1, OP_LW);
    for (int k = 1; k <= T; k++) begin
      drive(0, OP_LW);
      expect_eq("rd_timeout_state", 32'(state), 4);
      expect_eq("rd_timeout_err", 32'(mem_err), (k == T) ? 1 : 0);
    end
    drive(0, OP_LW);
    expect_eq("rd_timeout_to_fetch", 32'(state), 1);
    expect_eq("rd_timeout_no_reg", {30'd0, reg_write, mem_err}, 0);

    // FETCH stalls until its own timeout and restarts
    for (int k = 2; k <= T; k++) drive(0, OP_BAD);
    expect_eq("fetch_timeout_err", {29'd0, mem_err, ir_write, state == 4'd1}, 32'h5);
    drive(1, OP_BAD);
    expect_eq("fetch_restart", {29'd0, mem_err, ir_write, state == 4'd1}, 32'h3);

    // unsupported opcode
    drive(1, OP_BAD); expect_eq("illegal_pulse", {28'd0, state}, 2);
    expect_eq("illegal_flag", 32'(illegal_op), 1);
    drive(1, OP_BAD); expect_eq("illegal_to_fetch", {27'd0, illegal_op, state}, 1);

    // asynchronous reset while MEM_WB drives reg_write
    drive(1, OP_LW); drive(1, OP_LW); drive(1, OP_LW); drive(1, OP_LW);
    expect_eq("pre_reset_memwb", {27'd0, reg_write, state}, 32'h15);
    #1 rst_n = 1'b0;
    #1 expect_eq("async_reset_drop", {27'd0, reg_write, state}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    expect_eq("post_reset_idle", 32'(state), 0);

    // randomized traffic, with occasional stuck-memory windows to reach timeouts
    for (int seg = 0; seg < 80; seg++) begin
      bit stuck;
      stuck = ($urandom_range(0, 4) == 0);
      for (int c = 0; c < 40; c++) begin
        int idx;
        logic [5:0] op;
        idx = $urandom_range(0, 7);
        op  = (idx == 7) ? 6'($urandom) : opTab[idx];
        drive(stuck ? 1'b0 : ($urandom_range(0, 99) < 65), op);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
